// File: rtl/arduino_adc_led_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : arduino_adc_led_scheduler
// Purpose  : Round-robin arbiter sharing the 4-bit LED PIO between on-chip
//            requesters. Each grant issues one Avalon-MM write of the
//            winner's pattern to PIO register 0, then holds for a dwell.
// Revision : 1.0 - initial release
// ============================================================================
module arduino_adc_led_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LED_WIDTH   = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   pattern,
    output logic [NUM_REQ-1:0]             ack,
    output logic [1:0]                     avm_address,
    output logic                           avm_chipselect,
    output logic                           avm_write_n,
    output logic [31:0]                    avm_writedata,
    output logic [2:0]                     grant_id,
    output logic                           busy
);

    // Dwell counter needs at least one bit even when the dwell is zero.
    localparam int         C_CNT_W    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [2:0] C_LAST_RST = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_last_grant;
    logic [C_CNT_W-1:0]   r_hold_cnt;

    logic                 w_found;
    logic [2:0]           w_winner;
    logic [3:0]           w_idx;
    logic [7:0]           w_req_pad;
    logic [LED_WIDTH-1:0] w_pat;
    logic [NUM_REQ-1:0]   w_ack;

    // The PIO only has one register of interest.
    assign avm_address = 2'b00;
    assign grant_id    = r_last_grant;
    assign w_req_pad   = 8'(req);

    // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_idx    = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + 4'(k);
            if (w_idx >= 4'(NUM_REQ)) begin
                w_idx = w_idx - 4'(NUM_REQ);
            end
            if (!w_found && w_req_pad[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    // Winner's pattern and one-hot ack, decoded with constant slices.
    always_comb begin
        w_pat = '0;
        w_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_pat    = pattern[i*LED_WIDTH +: LED_WIDTH];
                w_ack[i] = 1'b1;
            end
        end
    end

    // Scheduler FSM; every bus-facing output is registered here. The pattern
    // is captured straight into avm_writedata at arbitration, so later
    // pattern changes cannot disturb the write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= C_LAST_RST;
            r_hold_cnt     <= '0;
            busy           <= 1'b0;
            ack            <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state        <= ST_WRITE;
                        r_last_grant   <= w_winner;
                        ack            <= w_ack;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_writedata  <= 32'(w_pat);
                        busy           <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // No waitrequest on the PIO: the write is done this cycle.
                    ack            <= '0;
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    avm_writedata  <= 32'd0;
                    r_hold_cnt     <= C_CNT_W'(HOLD_CYCLES);
                    if (HOLD_CYCLES == 0) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt - 1'b1;
                    if (r_hold_cnt <= C_CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arduino_adc_led_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_arduino_adc_led_scheduler
// Purpose  : Directed self-checking bench for arduino_adc_led_scheduler,
//            using three instances with dwell 3, 0 and 1000 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arduino_adc_led_scheduler;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  req3,  req0,  req1k;
    logic [15:0] pat3,  pat0,  pat1k;
    logic [3:0]  ack3,  ack0,  ack1k;
    logic [1:0]  addr3, addr0, addr1k;
    logic        cs3,   cs0,   cs1k;
    logic        wn3,   wn0,   wn1k;
    logic [31:0] wd3,   wd0,   wd1k;
    logic [2:0]  gid3,  gid0,  gid1k;
    logic        busy3, busy0, busy1k;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arduino_adc_led_scheduler #(.NUM_REQ(4), .LED_WIDTH(4), .HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .reset(reset), .req(req3), .pattern(pat3), .ack(ack3),
        .avm_address(addr3), .avm_chipselect(cs3), .avm_write_n(wn3),
        .avm_writedata(wd3), .grant_id(gid3), .busy(busy3)
    );

    arduino_adc_led_scheduler #(.NUM_REQ(4), .LED_WIDTH(4), .HOLD_CYCLES(0)) u_h0 (
        .clk(clk), .reset(reset), .req(req0), .pattern(pat0), .ack(ack0),
        .avm_address(addr0), .avm_chipselect(cs0), .avm_write_n(wn0),
        .avm_writedata(wd0), .grant_id(gid0), .busy(busy0)
    );

    arduino_adc_led_scheduler #(.NUM_REQ(4), .LED_WIDTH(4), .HOLD_CYCLES(1000)) u_h1k (
        .clk(clk), .reset(reset), .req(req1k), .pattern(pat1k), .ack(ack1k),
        .avm_address(addr1k), .avm_chipselect(cs1k), .avm_write_n(wn1k),
        .avm_writedata(wd1k), .grant_id(gid1k), .busy(busy1k)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_busy, n_wr, n_ack, any_cs, any_wn0, any_busy, any_ack;
        int g[3];
        int d[3];
        int wi[3];
        logic [3:0] ack_or;
        int exp_g;

        reset = 1'b1;
        req3 = '0; req0 = '0; req1k = '0;
        pat3 = '0; pat0 = '0; pat1k = '0;
        #1;
        chk("rst_async_cs",   32'(cs3),   32'd0);
        repeat (3) step();

        // Reset values
        chk("rst_cs",   32'(cs3),   32'd0);
        chk("rst_wn",   32'(wn3),   32'd1);
        chk("rst_wd",   wd3,        32'd0);
        chk("rst_ack",  32'(ack3),  32'd0);
        chk("rst_gid",  32'(gid3),  32'd3);
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_addr", 32'(addr3), 32'd0);
        reset = 1'b0;

        // No requests for 100 cycles: bus stays quiet on every instance
        any_cs = 0; any_wn0 = 0; any_busy = 0; any_ack = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cs3 || cs0 || cs1k)          any_cs++;
            if (!wn3 || !wn0 || !wn1k)       any_wn0++;
            if (busy3 || busy0 || busy1k)    any_busy++;
            if ((ack3 | ack0 | ack1k) != 0)  any_ack++;
        end
        chk("idle_cs",   32'(any_cs),   32'd0);
        chk("idle_wn",   32'(any_wn0),  32'd0);
        chk("idle_busy", 32'(any_busy), 32'd0);
        chk("idle_ack",  32'(any_ack),  32'd0);

        // Single request, dwell 3: one write, busy for 4 cycles
        req3 = 4'b0001;
        pat3 = 16'h000A;
        n_busy = 0; n_wr = 0; n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                chk("s_cs",   32'(cs3),   32'd1);
                chk("s_wn",   32'(wn3),   32'd0);
                chk("s_addr", 32'(addr3), 32'd0);
                chk("s_wd",   wd3,        32'h0000000A);
                chk("s_ack",  32'(ack3),  32'b0001);
                chk("s_gid",  32'(gid3),  32'd0);
                req3 = 4'b0000;
            end
            if (busy3)     n_busy++;
            if (cs3)       n_wr++;
            if (ack3 != 0) n_ack++;
        end
        chk("s_busy_cycles", 32'(n_busy), 32'd4);
        chk("s_writes",      32'(n_wr),   32'd1);
        chk("s_ack_cycles",  32'(n_ack),  32'd1);
        chk("s_end_busy",    32'(busy3),  32'd0);
        chk("s_end_wd",      wd3,         32'd0);

        // req=0101 after grant to 0: grants 2,0,2; pattern2 changes 3->C mid-hold
        req3 = 4'b0101;
        pat3 = 16'hE395;
        n_wr = 0;
        ack_or = '0;
        for (int i = 0; i < 15; i++) begin
            step();
            ack_or |= ack3;
            if (cs3) begin
                if (n_wr < 3) begin
                    g[n_wr]  = int'(gid3);
                    d[n_wr]  = int'(wd3);
                    wi[n_wr] = i;
                end
                chk("rr_ack_onehot", 32'(ack3), 32'(4'b0001 << gid3));
                n_wr++;
            end
            if (i == 2) pat3[11:8] = 4'hC;
        end
        req3 = 4'b0000;
        chk("rr_writes", 32'(n_wr), 32'd3);
        chk("rr_g0", 32'(g[0]), 32'd2);
        chk("rr_d0", 32'(d[0]), 32'h3);
        chk("rr_g1", 32'(g[1]), 32'd0);
        chk("rr_d1", 32'(d[1]), 32'h5);
        chk("rr_g2", 32'(g[2]), 32'd2);
        chk("rr_d2", 32'(d[2]), 32'hC);
        chk("rr_t1", 32'(wi[1]), 32'd5);
        chk("rr_t2", 32'(wi[2]), 32'd10);
        chk("rr_ack_or", 32'(ack_or), 32'b0101);

        // Dwell 0, all requesting: grants 0,1,2,3,0 every 2 cycles
        req0 = 4'b1111;
        pat0 = 16'h4321;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("h0_cs",   32'(cs0),   (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("h0_busy", 32'(busy0), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                exp_g = (i / 2) % 4;
                chk("h0_gid", 32'(gid0), 32'(exp_g));
                chk("h0_ack", 32'(ack0), 32'(1 << exp_g));
                chk("h0_wd",  wd0,       32'(exp_g + 1));
            end else begin
                chk("h0_ack_low", 32'(ack0), 32'd0);
            end
        end
        req0 = 4'b0000;

        // Dwell 1000: reset in mid-hold, then requester 3 alone
        req1k = 4'b0001;
        pat1k = 16'h8001;
        step();
        chk("k_cs",  32'(cs1k),  32'd1);
        chk("k_gid", 32'(gid1k), 32'd0);
        req1k = 4'b0000;
        repeat (500) step();
        chk("k_mid_busy", 32'(busy1k), 32'd1);
        chk("k_mid_cs",   32'(cs1k),   32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("k_rst_busy", 32'(busy1k), 32'd0);
        chk("k_rst_gid",  32'(gid1k),  32'd3);
        chk("k_rst_cs",   32'(cs1k),   32'd0);
        chk("k_rst_wn",   32'(wn1k),   32'd1);
        chk("k_rst_ack",  32'(ack1k),  32'd0);
        chk("k_rst_wd",   wd1k,        32'd0);
        repeat (3) step();
        reset = 1'b0;
        any_cs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cs1k || busy1k) any_cs++;
        end
        chk("k_no_replay", 32'(any_cs), 32'd0);
        req1k = 4'b1000;
        step();
        chk("k3_cs",  32'(cs1k),  32'd1);
        chk("k3_gid", 32'(gid1k), 32'd3);
        chk("k3_ack", 32'(ack1k), 32'b1000);
        chk("k3_wd",  wd1k,       32'h8);
        req1k = 4'b0000;
        step();
        chk("k3_ack_end", 32'(ack1k), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
